ro_puf_eval: RTL and testbench

- Parametrised ring-oscillator PUF evaluator, next generation of the fixed 16-RO, single-compare design.
- For each response bit, picks an RO pair from an LFSR seeded by the challenge, counts both ROs over a clk-timed window, and compares the counts.
- Assembles a multi-bit response with a per-bit tie (unstable) mask.
- Sits between the RO bank (oscillators in their own module, pre-divided externally) and the host/IO logic.

---
 rtl/puf_pkg.sv | 26 ++
 rtl/ro_edge_counter.sv | 46 ++++
 rtl/ro_puf_eval.sv | 198 +++++++++++++++++++
 tb/tb_ro_puf_eval.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared definitions for the ring-oscillator PUF evaluator.
//   state_e        : evaluator FSM states
//   LFSR_TAPS      : tap mask for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   LFSR_ZERO_SEED : substitute seed when the challenge is all zeros
//   SETTLE_CYCLES  : synchroniser flush time after a new RO pair is selected
//   lfsr_step()    : one left shift of the Fibonacci LFSR, feedback into bit 0
package puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEL,
      ST_SETTLE,
      ST_MEASURE,
      ST_CMP,
      ST_DONE
   } state_e;

   localparam logic [15:0] LFSR_TAPS      = 16'hB400;
   localparam logic [15:0] LFSR_ZERO_SEED = 16'hACE1;
   localparam int unsigned SETTLE_CYCLES  = 2;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Rising-edge counter for one asynchronous RO signal.
//   clk, rst_n : system clock, asynchronous active-low reset
//   ro_i       : asynchronous oscillator input (already muxed)
//   clr_i      : synchronous clear of the count
//   en_i       : count enable (measurement window)
//   cnt_o      : saturating edge count
module ro_edge_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ro_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);

   // sync_q[0..1] form the 2-flop synchroniser, sync_q[2] holds the previous sample
   logic [2:0]       sync_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rise;

   assign rise = sync_q[1] & ~sync_q[2];

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && rise && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[1:0], ro_i};
         cnt_q  <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ro_puf_eval.sv
// Ring-oscillator PUF evaluator. For each response bit an LFSR (seeded by the
// challenge) picks an RO pair, both ROs are edge-counted over a win_len-cycle
// window, and the counts are compared.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   start               : begin evaluation (accepted in IDLE only)
//   challenge, win_len  : LFSR seed and window length, latched on accepted start
//   ro_in               : asynchronous RO outputs
//   busy, done          : evaluation in progress / one-cycle completion pulse
//   response, tie_mask  : per-bit result (a > b) and equal-count flags
//   dbg_cnt_a/b         : counts of the most recently compared pair
module ro_puf_eval
   import puf_pkg::*;
#(
   parameter int unsigned N_RO      = 16,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned WIN_W     = 16,
   parameter int unsigned RESP_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [15:0]          challenge,
   input  logic [WIN_W-1:0]     win_len,
   input  logic [N_RO-1:0]      ro_in,
   output logic                 busy,
   output logic                 done,
   output logic [RESP_BITS-1:0] response,
   output logic [RESP_BITS-1:0] tie_mask,
   output logic [CNT_W-1:0]     dbg_cnt_a,
   output logic [CNT_W-1:0]     dbg_cnt_b
);

   localparam int unsigned SEL_W = $clog2(N_RO);
   localparam int unsigned K_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

   state_e               state_q, state_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic [WIN_W-1:0]     win_q, win_d;
   logic [WIN_W-1:0]     timer_q, timer_d;
   logic [K_W-1:0]       bit_q, bit_d;
   logic [SEL_W-1:0]     idx_a_q, idx_a_d;
   logic [SEL_W-1:0]     idx_b_q, idx_b_d;
   logic [RESP_BITS-1:0] resp_q, resp_d;
   logic [RESP_BITS-1:0] tie_q, tie_d;
   logic [CNT_W-1:0]     dbg_a_q, dbg_a_d;
   logic [CNT_W-1:0]     dbg_b_q, dbg_b_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [SEL_W-1:0]     sel_a, sel_b_raw, sel_b;
   logic [SEL_W-1:0]     mux_a, mux_b;
   logic                 cnt_clr, cnt_en;
   logic [CNT_W-1:0]     cnt_a, cnt_b;

   // Pair chosen from the current LFSR value; equal indices are forced apart.
   assign sel_a     = lfsr_q[SEL_W-1:0];
   assign sel_b_raw = lfsr_q[2*SEL_W-1:SEL_W];
   assign sel_b     = (sel_b_raw == sel_a) ? sel_a + 1'b1 : sel_b_raw;

   // The muxes follow the new pair already during SEL so that the synchroniser
   // holds only samples of the new ROs by the time MEASURE starts.
   assign mux_a = (state_q == ST_SEL) ? sel_a : idx_a_q;
   assign mux_b = (state_q == ST_SEL) ? sel_b : idx_b_q;

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .clk   (clk),
      .rst_n (rst_n),
      .ro_i  (ro_in[mux_a]),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .cnt_o (cnt_a)
   );

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .clk   (clk),
      .rst_n (rst_n),
      .ro_i  (ro_in[mux_b]),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .cnt_o (cnt_b)
   );

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      win_d   = win_q;
      timer_d = timer_q;
      bit_d   = bit_q;
      idx_a_d = idx_a_q;
      idx_b_d = idx_b_q;
      resp_d  = resp_q;
      tie_d   = tie_q;
      dbg_a_d = dbg_a_q;
      dbg_b_d = dbg_b_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               lfsr_d  = (challenge == '0) ? LFSR_ZERO_SEED : challenge;
               win_d   = (win_len == '0) ? WIN_W'(1) : win_len;
               resp_d  = '0;
               tie_d   = '0;
               bit_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_SEL;
            end
         end
         ST_SEL: begin
            idx_a_d = sel_a;
            idx_b_d = sel_b;
            cnt_clr = 1'b1;
            lfsr_d  = lfsr_step(lfsr_q);
            timer_d = '0;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (timer_q == WIN_W'(SETTLE_CYCLES - 1)) begin
               timer_d = '0;
               state_d = ST_MEASURE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_MEASURE: begin
            cnt_en = 1'b1;
            if (timer_q == win_q - 1'b1) begin
               state_d = ST_CMP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_CMP: begin
            resp_d[bit_q] = (cnt_a > cnt_b);
            tie_d[bit_q]  = (cnt_a == cnt_b);
            dbg_a_d       = cnt_a;
            dbg_b_d       = cnt_b;
            if (bit_q == K_W'(RESP_BITS - 1)) begin
               state_d = ST_DONE;
            end else begin
               bit_d   = bit_q + 1'b1;
               state_d = ST_SEL;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         lfsr_q  <= '0;
         win_q   <= '0;
         timer_q <= '0;
         bit_q   <= '0;
         idx_a_q <= '0;
         idx_b_q <= '0;
         resp_q  <= '0;
         tie_q   <= '0;
         dbg_a_q <= '0;
         dbg_b_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         win_q   <= win_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         idx_a_q <= idx_a_d;
         idx_b_q <= idx_b_d;
         resp_q  <= resp_d;
         tie_q   <= tie_d;
         dbg_a_q <= dbg_a_d;
         dbg_b_q <= dbg_b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign response  = resp_q;
   assign tie_mask  = tie_q;
   assign dbg_cnt_a = dbg_a_q;
   assign dbg_cnt_b = dbg_b_q;

endmodule

// File: tb/tb_ro_puf_eval.sv
// Self-checking bench for ro_puf_eval: DUT0 uses CNT_W=16, DUT1 uses CNT_W=4.
// A behavioural model records every sampled RO value and, for each accepted
// start, derives pair indices, rising-edge counts, response and timing.
module tb_ro_puf_eval;

   localparam int NR   = 16;
   localparam int RB   = 8;
   localparam int HMAX = 16384;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  start_v = '0;
   logic [15:0] chal_v = '0;
   logic [15:0] wl_v = '0;
   logic [15:0] ro_v = '0;

   logic        busy0, done0, busy1, done1;
   logic [7:0]  resp0, tie0, resp1, tie1;
   logic [15:0] ca0, cb0;
   logic [3:0]  ca1, cb1;

   always #5 clk = ~clk;

   ro_puf_eval #(.N_RO(16), .CNT_W(16), .WIN_W(16), .RESP_BITS(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .challenge(chal_v),
      .win_len(wl_v), .ro_in(ro_v), .busy(busy0), .done(done0),
      .response(resp0), .tie_mask(tie0), .dbg_cnt_a(ca0), .dbg_cnt_b(cb0)
   );

   ro_puf_eval #(.N_RO(16), .CNT_W(4), .WIN_W(16), .RESP_BITS(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .challenge(chal_v),
      .win_len(wl_v), .ro_in(ro_v), .busy(busy1), .done(done1),
      .response(resp1), .tie_mask(tie1), .dbg_cnt_a(ca1), .dbg_cnt_b(cb1)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // RO waveform: period per[k] clk cycles, high for the first half
   int per [NR];
   int ph  [NR];
   logic [15:0] hist [HMAX];

   // model state per DUT
   bit          m_act  [2];
   bit          m_dexp [2];
   int          m_t0   [2];
   int          m_dat  [2];
   int          m_w    [2];
   logic [15:0] m_seed [2];
   logic [7:0]  m_resp [2];
   logic [7:0]  m_tie  [2];
   logic [15:0] m_ca   [2];
   logic [15:0] m_cb   [2];
   int          m_cmax [2] = '{65535, 15};

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, d, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      int v, fb;
      v  = int'(s);
      fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
      return 16'((v * 2 + fb) % 65536);
   endfunction

   task automatic get_pair(input logic [15:0] seed0, input int k, output int a, output int b);
      logic [15:0] s;
      s = seed0;
      for (int i = 0; i < k; i++) s = lfsr_next(s);
      a = int'(s) % NR;
      b = (int'(s) / NR) % NR;
      if (a == b) b = (a + 1) % NR;
   endtask

   // counts rising transitions over the W sample steps following pair selection
   task automatic model_eval(input int d);
      int a, b, na, nb, e0;
      for (int k = 0; k < RB; k++) begin
         get_pair(m_seed[d], k, a, b);
         e0 = m_t0[d] + 1 + k * (m_w[d] + 4);
         na = 0;
         nb = 0;
         for (int j = e0 + 1; j <= e0 + m_w[d]; j++) begin
            if (hist[j][a] && !hist[j-1][a]) na++;
            if (hist[j][b] && !hist[j-1][b]) nb++;
         end
         if (na > m_cmax[d]) na = m_cmax[d];
         if (nb > m_cmax[d]) nb = m_cmax[d];
         m_resp[d][k] = (na > nb);
         m_tie[d][k]  = (na == nb);
         m_ca[d] = 16'(na);
         m_cb[d] = 16'(nb);
      end
   endtask

   // RO drivers, updated just after each rising edge
   initial begin
      for (int k = 0; k < NR; k++) begin per[k] = 8; ph[k] = 0; end
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < NR; k++)
            ro_v[k] = (((cyc + ph[k]) % per[k]) < (per[k] / 2));
      end
   end

   // behavioural model, advanced on each rising edge
   initial begin
      for (int d = 0; d < 2; d++) begin
         m_act[d] = 0; m_dexp[d] = 0; m_resp[d] = '0; m_tie[d] = '0;
         m_ca[d] = '0; m_cb[d] = '0; m_t0[d] = 0; m_dat[d] = 0; m_w[d] = 1; m_seed[d] = '0;
      end
      forever begin
         @(posedge clk);
         if (cyc < HMAX) hist[cyc] = ro_v;
         for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
               m_act[d] = 0; m_dexp[d] = 0; m_resp[d] = '0; m_tie[d] = '0;
               m_ca[d] = '0; m_cb[d] = '0;
            end else begin
               m_dexp[d] = 0;
               if (m_act[d] && cyc == m_dat[d]) begin
                  model_eval(d);
                  m_act[d]  = 0;
                  m_dexp[d] = 1;
               end else if (!m_act[d] && start_v[d]) begin
                  m_t0[d]   = cyc;
                  m_seed[d] = (chal_v == 16'h0) ? 16'hACE1 : chal_v;
                  m_w[d]    = (wl_v == 16'h0) ? 1 : int'(wl_v);
                  m_dat[d]  = cyc + RB * (m_w[d] + 4) + 1;
                  m_act[d]  = 1;
                  m_resp[d] = '0;
                  m_tie[d]  = '0;
               end
            end
         end
         cyc++;
      end
   end

   task automatic check_dut(input int d, input logic b, input logic dn, input logic [7:0] r,
                            input logic [7:0] t, input logic [15:0] a, input logic [15:0] c);
      chk("busy", d, 32'(b), 32'(m_act[d]));
      chk("done", d, 32'(dn), 32'(m_dexp[d]));
      if (!m_act[d]) begin
         chk("response", d, 32'(r), 32'(m_resp[d]));
         chk("tie_mask", d, 32'(t), 32'(m_tie[d]));
         chk("dbg_cnt_a", d, 32'(a), 32'(m_ca[d]));
         chk("dbg_cnt_b", d, 32'(c), 32'(m_cb[d]));
      end
   endtask

   // compare process: mid-cycle, every cycle out of reset
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            check_dut(0, busy0, done0, resp0, tie0, ca0, cb0);
            check_dut(1, busy1, done1, resp1, tie1, {12'h0, ca1}, {12'h0, cb1});
         end
      end
   end

   task automatic check_zero(input string nm);
      chk({nm, "_busy0"}, 0, 32'(busy0), 0);
      chk({nm, "_done0"}, 0, 32'(done0), 0);
      chk({nm, "_resp0"}, 0, 32'(resp0), 0);
      chk({nm, "_tie0"}, 0, 32'(tie0), 0);
      chk({nm, "_cnta0"}, 0, 32'(ca0), 0);
      chk({nm, "_cntb0"}, 0, 32'(cb0), 0);
   endtask

   // one evaluation: optional second start at ipt_at, optional reset at rst_at
   task automatic run_eval(input int d, input logic [15:0] chal, input logic [15:0] wl,
                           input int exp_lat, input int ipt_at, input int rst_at);
      int  lat;
      bit  got;
      lat = 0;
      got = 0;
      @(posedge clk); #2;
      chal_v = chal; wl_v = wl; start_v[d] = 1'b1;
      @(posedge clk); #2;
      start_v[d] = 1'b0;
      while (lat < exp_lat + 40) begin
         @(posedge clk);
         lat++;
         #1;
         if (lat == rst_at) begin
            #1;
            rst_n = 1'b0;
            #1;
            check_zero("reset_mid");
            repeat (3) @(posedge clk);
            #2;
            rst_n = 1'b1;
            return;
         end
         if ((d == 0 && done0) || (d == 1 && done1)) begin
            got = 1;
            break;
         end
         if (lat == ipt_at) begin
            #1;
            chal_v = ~chal;
            start_v[d] = 1'b1;
         end else if (lat == ipt_at + 1) begin
            start_v[d] = 1'b0;
         end
      end
      if (got) begin
         chk("latency", d, 32'(lat), 32'(exp_lat));
      end else begin
         checks++;
         failures++;
         $display("FAIL done_timeout dut%0d: no done within %0d cycles, required %0d", d, lat, exp_lat);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
      $fatal(1);
   end

   initial begin
      logic [15:0] c, seed;
      logic [7:0]  er, et;
      int a, b, w;

      repeat (3) @(posedge clk);
      #2;
      check_zero("reset");
      chk("reset_busy1", 1, 32'(busy1), 0);
      chk("reset_tie1", 1, 32'(tie1), 0);
      rst_n = 1'b1;

      // frequency difference: even ROs period 8, odd period 12, W=96
      for (int k = 0; k < NR; k++) begin per[k] = (k % 2 == 0) ? 8 : 12; ph[k] = 0; end
      repeat (2) @(posedge clk);
      c = 16'($urandom);
      run_eval(0, c, 16'd96, 801, 0, 0);
      seed = (c == 16'h0) ? 16'hACE1 : c;
      er = '0; et = '0;
      for (int k = 0; k < RB; k++) begin
         get_pair(seed, k, a, b);
         er[k] = (a % 2 == 0) && (b % 2 == 1);
         et[k] = ((a % 2) == (b % 2));
      end
      chk("freq_resp", 0, 32'(resp0), 32'(er));
      chk("freq_tie", 0, 32'(tie0), 32'(et));
      chk("freq_cnt_a", 0, 32'(ca0), (a % 2 == 0) ? 12 : 8);
      chk("freq_cnt_b", 0, 32'(cb0), (b % 2 == 0) ? 12 : 8);

      // tie: all ROs period 10, W=100
      for (int k = 0; k < NR; k++) per[k] = 10;
      repeat (2) @(posedge clk);
      run_eval(0, 16'($urandom), 16'd100, 8 * 104 + 1, 0, 0);
      chk("tie_resp", 0, 32'(resp0), 0);
      chk("tie_mask", 0, 32'(tie0), 32'hFF);
      chk("tie_cnt_a", 0, 32'(ca0), 10);
      chk("tie_cnt_b", 0, 32'(cb0), 10);

      // degenerate: zero window and zero challenge
      run_eval(0, 16'h0, 16'h0, 8 * 5 + 1, 0, 0);
      for (int k = 0; k < RB; k++) begin
         get_pair(16'hACE1, k, a, b);
         chk("degen_pair_distinct", k, 32'(a != b), 1);
      end

      // saturation on the 4-bit counter instance
      for (int k = 0; k < NR; k++) per[k] = (k % 2 == 0) ? 4 : 6;
      repeat (2) @(posedge clk);
      run_eval(1, 16'($urandom), 16'd200, 8 * 204 + 1, 0, 0);
      chk("sat_resp", 1, 32'(resp1), 0);
      chk("sat_tie", 1, 32'(tie1), 32'hFF);
      chk("sat_cnt_a", 1, 32'(ca1), 15);
      chk("sat_cnt_b", 1, 32'(cb1), 15);

      // start while busy: second pulse mid-MEASURE of bit 0 is ignored
      for (int k = 0; k < NR; k++) per[k] = (k % 2 == 0) ? 8 : 12;
      repeat (2) @(posedge clk);
      run_eval(0, 16'($urandom), 16'd20, 8 * 24 + 1, 10, 0);

      // reset during bit 3 MEASURE, then a full evaluation
      run_eval(0, 16'($urandom), 16'd30, 8 * 34 + 1, 0, 3 * 34 + 13);
      repeat (5) @(posedge clk);
      #1;
      chk("post_reset_done", 0, 32'(done0), 0);
      run_eval(0, 16'($urandom), 16'd30, 8 * 34 + 1, 0, 0);

      // randomized patterns on both instances
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < NR; k++) begin
            per[k] = $urandom_range(15, 4);
            ph[k]  = $urandom_range(15, 0);
         end
         repeat (2) @(posedge clk);
         w = $urandom_range(24, 0);
         run_eval(i % 2, 16'($urandom), 16'(w), 8 * (((w == 0) ? 1 : w) + 4) + 1, 0, 0);
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
